// File: rtl/frame_ingest_pp_pkg.sv
// Shared types and helpers for the UART frame ingest block.
package frame_ingest_pp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DISCARD = 2'd2
    } ingest_state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic int width_for(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_ingest_pp_if.sv
// Byte input, bank write port and frame hand-off bundle of frame_ingest_pp.
interface frame_ingest_pp_if
    import frame_ingest_pp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 1,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int NUM_BANKS  = 2
) ();
    localparam int AW = width_for(CHANNELS * IMG_W * IMG_H);
    localparam int BW = width_for(NUM_BANKS);

    logic                  rx_dv;
    logic [7:0]            rx_byte;
    logic                  wr_en;
    logic [BW-1:0]         wr_bank;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  frame_valid;
    logic [BW-1:0]         frame_bank;
    logic                  frame_accept;
    logic                  frame_release;
    logic                  busy;
    logic [15:0]           drop_cnt;
    logic [15:0]           resync_cnt;

    modport slave (
        input  rx_dv, rx_byte, frame_accept, frame_release,
        output wr_en, wr_bank, wr_addr, wr_data, frame_valid, frame_bank,
               busy, drop_cnt, resync_cnt
    );

    modport master (
        output rx_dv, rx_byte, frame_accept, frame_release,
        input  wr_en, wr_bank, wr_addr, wr_data, frame_valid, frame_bank,
               busy, drop_cnt, resync_cnt
    );
endinterface

// File: rtl/frame_ingest_pp_pix_norm_lut.sv
// Registered byte-to-fixed-point lookup: v = (k*2^F + 127)/255, optionally centred.
module frame_ingest_pp_pix_norm_lut #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 7,
    parameter int NORM_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic [DATA_WIDTH-1:0] lut_s [256];
    logic [DATA_WIDTH-1:0] data_q;

    for (genvar k = 0; k < 256; k++) begin : g_lut
        localparam int UNSIGNED_V = (k * (1 << FRAC_BITS) + 127) / 255;
        localparam int OFFSET_V   = (NORM_MODE != 0) ? (1 << (FRAC_BITS - 1)) : 0;
        assign lut_s[k] = DATA_WIDTH'(UNSIGNED_V - OFFSET_V);
    end

    // Output register; holds the last converted byte between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= lut_s[byte_i];
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/frame_ingest_pp.sv
// UART pixel ingest: HWC bytes in, CHW fixed-point writes into round-robin banks.
module frame_ingest_pp
    import frame_ingest_pp_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int FRAC_BITS       = 7,
    parameter int IMG_W           = 28,
    parameter int IMG_H           = 28,
    parameter int CHANNELS        = 1,
    parameter int NUM_BANKS       = 2,
    parameter int GAP_TIMEOUT_CYC = 100000,
    parameter int NORM_MODE       = 0
) (
    input logic              clk,
    input logic              reset,
    frame_ingest_pp_if.slave bus
);
    localparam int PLANE = IMG_H * IMG_W;
    localparam int AW    = width_for(CHANNELS * PLANE);
    localparam int BW    = width_for(NUM_BANKS);
    localparam int CW    = width_for(CHANNELS);
    localparam int OW    = width_for(NUM_BANKS + 1);
    localparam int GW    = width_for(GAP_TIMEOUT_CYC);

    ingest_state_t   state_q, state_d;
    logic [AW-1:0]   pix_q, pix_d, base_q, base_d, pix_n_s, base_n_s;
    logic [CW-1:0]   ch_q, ch_d, ch_n_s;
    logic [GW-1:0]   gap_q, gap_d;
    logic [BW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d, pend_q, pend_d;
    logic            held_q, held_d;
    logic [15:0]     drop_q, drop_d, resync_q, resync_d;
    logic            wr_en_q, frame_valid_q;
    logic [BW-1:0]   wr_bank_q, frame_bank_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic            take_s, last_s, timeout_s, complete_s, accept_s, release_s;

    function automatic logic [BW-1:0] bank_next(input logic [BW-1:0] p);
        return (p == BW'(NUM_BANKS - 1)) ? '0 : p + BW'(1);
    endfunction

    assign take_s     = bus.rx_dv && ((state_q == FILL) ||
                        ((state_q == IDLE) && (occ_q < OW'(NUM_BANKS))));
    assign last_s     = (ch_q == CW'(CHANNELS - 1)) && (pix_q == AW'(PLANE - 1));
    assign timeout_s  = !bus.rx_dv && (state_q != IDLE) &&
                        (gap_q == GW'(GAP_TIMEOUT_CYC - 1));
    assign complete_s = take_s && last_s;
    // A held bank hides frame_valid, so an accept alongside a release is dropped here.
    assign accept_s   = bus.frame_accept && frame_valid_q;
    assign release_s  = bus.frame_release && held_q;

    assign wr_ptr_d = complete_s ? bank_next(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d = release_s ? bank_next(rd_ptr_q) : rd_ptr_q;
    assign held_d   = release_s ? 1'b0 : (accept_s ? 1'b1 : held_q);
    assign occ_d    = occ_q + OW'(complete_s) - OW'(release_s);
    assign pend_d   = pend_q + OW'(complete_s) - OW'(accept_s);
    assign drop_d   = (bus.rx_dv && !take_s && last_s) ? sat_inc(drop_q) : drop_q;
    assign resync_d = timeout_s ? sat_inc(resync_q) : resync_q;

    // Next HWC position: channel is the fast index, the plane offset steps by PLANE.
    always_comb begin
        ch_n_s   = '0;
        base_n_s = '0;
        pix_n_s  = '0;
        if (last_s) begin
            ch_n_s   = '0;
            base_n_s = '0;
            pix_n_s  = '0;
        end else if (ch_q == CW'(CHANNELS - 1)) begin
            ch_n_s   = '0;
            base_n_s = '0;
            pix_n_s  = pix_q + AW'(1);
        end else begin
            ch_n_s   = ch_q + CW'(1);
            base_n_s = base_q + AW'(PLANE);
            pix_n_s  = pix_q;
        end
    end

    // Ingest FSM; a byte arriving on the expiry cycle clears the gap and wins.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        base_d  = base_q;
        pix_d   = pix_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (bus.rx_dv) begin
                    ch_d    = ch_n_s;
                    base_d  = base_n_s;
                    pix_d   = pix_n_s;
                    state_d = last_s ? IDLE : (take_s ? FILL : DISCARD);
                end else begin
                    state_d = IDLE;
                end
            end
            FILL, DISCARD: begin
                if (bus.rx_dv) begin
                    ch_d    = ch_n_s;
                    base_d  = base_n_s;
                    pix_d   = pix_n_s;
                    gap_d   = '0;
                    state_d = last_s ? IDLE : state_q;
                end else if (timeout_s) begin
                    ch_d    = '0;
                    base_d  = '0;
                    pix_d   = '0;
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d   = gap_q + GW'(1);
                end
            end
            default: begin
                ch_d    = '0;
                base_d  = '0;
                pix_d   = '0;
                gap_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, position, bank bookkeeping and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            base_q   <= '0;
            pix_q    <= '0;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            pend_q   <= '0;
            held_q   <= 1'b0;
            drop_q   <= 16'd0;
            resync_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            base_q   <= base_d;
            pix_q    <= pix_d;
            gap_q    <= gap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            pend_q   <= pend_d;
            held_q   <= held_d;
            drop_q   <= drop_d;
            resync_q <= resync_d;
        end
    end

    // Registered write port and frame hand-off outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q       <= 1'b0;
            wr_bank_q     <= '0;
            wr_addr_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_bank_q  <= '0;
        end else begin
            wr_en_q <= take_s;
            if (take_s) begin
                wr_bank_q <= wr_ptr_q;
                wr_addr_q <= base_q + pix_q;
            end
            frame_valid_q <= (pend_d != '0) && !held_d;
            frame_bank_q  <= rd_ptr_d;
        end
    end

    frame_ingest_pp_pix_norm_lut #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .NORM_MODE  (NORM_MODE)
    ) u_lut (
        .clk    (clk),
        .reset  (reset),
        .en_i   (take_s),
        .byte_i (bus.rx_byte),
        .data_o (wr_data_s)
    );

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_bank     = wr_bank_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_s;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_bank  = frame_bank_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.drop_cnt    = drop_q;
    assign bus.resync_cnt  = resync_q;
endmodule
